// File: rtl/prm_edge_chk_seq.sv
// ============================================================================
// Module   : prm_edge_chk_seq
// Purpose  : Streams edge sample codes through an external obstacle checker and
//            reduces the per-sample masks to one blocked/first/hits result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prm_edge_chk_seq #(
    parameter int MAX_SAMPLES = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [14:0]      s_code,
    input  logic             s_last,
    output logic [14:0]      chk_code,
    output logic             chk_valid,
    input  logic             chk_mask,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_blocked,
    output logic [IDX_W-1:0] m_first_idx,
    output logic [IDX_W:0]   m_hits,
    output logic             m_overflow
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] C_IDX_MAX  = IDX_W'(MAX_SAMPLES - 1);
    localparam logic [IDX_W:0]   C_HITS_MAX = '1;

    state_t           r_state;
    logic             r_started;
    logic             r_p_valid;
    logic [14:0]      r_p_code;
    logic [IDX_W-1:0] r_p_idx;
    logic             r_p_last;
    logic [IDX_W-1:0] r_next_idx;
    logic             r_idx_full;
    logic             r_ovf;
    logic             r_blocked;
    logic [IDX_W-1:0] r_first;
    logic [IDX_W:0]   r_hits;

    logic             w_s_xfer;
    logic             w_hit;
    logic             w_blocked_n;
    logic [IDX_W:0]   w_hits_n;
    logic [IDX_W-1:0] w_first_n;

    // Hold off new samples while the edge's final sample is still in stage 1.
    assign s_ready   = r_started && (r_state == RUN) && !(r_p_valid && r_p_last);
    assign w_s_xfer  = s_valid && s_ready;
    assign chk_code  = r_p_code;
    assign chk_valid = r_p_valid;

    assign w_hit       = r_p_valid && chk_mask;
    assign w_blocked_n = r_blocked | w_hit;
    assign w_hits_n    = (w_hit && (r_hits != C_HITS_MAX)) ? r_hits + 1'b1 : r_hits;
    assign w_first_n   = (w_hit && !r_blocked) ? r_p_idx : r_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_started   <= 1'b0;
            r_p_valid   <= 1'b0;
            r_p_code    <= '0;
            r_p_idx     <= '0;
            r_p_last    <= 1'b0;
            r_next_idx  <= '0;
            r_idx_full  <= 1'b0;
            r_ovf       <= 1'b0;
            r_blocked   <= 1'b0;
            r_first     <= '0;
            r_hits      <= '0;
            m_valid     <= 1'b0;
            m_blocked   <= 1'b0;
            m_first_idx <= '0;
            m_hits      <= '0;
            m_overflow  <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_p_valid <= w_s_xfer;

            if (w_s_xfer) begin
                r_p_code <= s_code;
                r_p_idx  <= r_next_idx;
                r_p_last <= s_last;
                // Index sticks at the top slot; anything after that is overflow.
                if (r_next_idx == C_IDX_MAX) begin
                    r_idx_full <= 1'b1;
                end else begin
                    r_next_idx <= r_next_idx + 1'b1;
                end
                if (r_idx_full) begin
                    r_ovf <= 1'b1;
                end
            end

            if (r_p_valid) begin
                r_blocked <= w_blocked_n;
                r_hits    <= w_hits_n;
                r_first   <= w_first_n;
            end

            case (r_state)
                RUN: begin
                    if (r_p_valid && r_p_last) begin
                        r_state     <= HOLD;
                        m_valid     <= 1'b1;
                        m_blocked   <= w_blocked_n;
                        m_first_idx <= w_first_n;
                        m_hits      <= w_hits_n;
                        m_overflow  <= r_ovf;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_state    <= RUN;
                        m_valid    <= 1'b0;
                        r_blocked  <= 1'b0;
                        r_hits     <= '0;
                        r_first    <= '0;
                        r_next_idx <= '0;
                        r_idx_full <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prm_edge_chk_seq.sv
// ============================================================================
// Module   : tb_prm_edge_chk_seq
// Purpose  : Randomized and directed stimulus for prm_edge_chk_seq, compared
//            against an edge-level reference model of the reduction.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prm_edge_chk_seq;

    localparam int MAX_SAMPLES = 64;
    localparam int IDX_W       = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [14:0]      s_code;
    logic             s_last;
    logic [14:0]      chk_code;
    logic             chk_valid;
    logic             chk_mask;
    logic             m_valid;
    logic             m_ready;
    logic             m_blocked;
    logic [IDX_W-1:0] m_first_idx;
    logic [IDX_W:0]   m_hits;
    logic             m_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [14:0] q_code[$];
    int e_blocked, e_first, e_hits, e_ovf;

    always #5 clk = ~clk;

    // Stand-in for the external obstacle checker: input O flags a collision.
    assign chk_mask = chk_code[14];

    prm_edge_chk_seq #(
        .MAX_SAMPLES(MAX_SAMPLES),
        .IDX_W      (IDX_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_code     (s_code),
        .s_last     (s_last),
        .chk_code   (chk_code),
        .chk_valid  (chk_valid),
        .chk_mask   (chk_mask),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_blocked  (m_blocked),
        .m_first_idx(m_first_idx),
        .m_hits     (m_hits),
        .m_overflow (m_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Edge-level reference: scan the sample list once.
    task automatic model();
        e_blocked = 0;
        e_first   = 0;
        e_hits    = 0;
        foreach (q_code[i]) begin
            if (q_code[i][14]) begin
                if (e_blocked == 0) e_first = (i > MAX_SAMPLES - 1) ? MAX_SAMPLES - 1 : i;
                e_blocked = 1;
                e_hits++;
            end
        end
        if (e_hits > 2 ** (IDX_W + 1) - 1) e_hits = 2 ** (IDX_W + 1) - 1;
        e_ovf = (q_code.size() > MAX_SAMPLES) ? 1 : 0;
    endtask

    task automatic make_edge(input int n, input int hit_pct);
        logic [14:0] c;
        q_code.delete();
        for (int i = 0; i < n; i++) begin
            c     = 15'($urandom);
            c[14] = ($urandom_range(99) < hit_pct);
            q_code.push_back(c);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},   s_ready,     0);
        check({tag, "_chk_valid"}, chk_valid,   0);
        check({tag, "_chk_code"},  chk_code,    0);
        check({tag, "_m_valid"},   m_valid,     0);
        check({tag, "_m_blocked"}, m_blocked,   0);
        check({tag, "_m_first"},   m_first_idx, 0);
        check({tag, "_m_hits"},    m_hits,      0);
        check({tag, "_m_ovf"},     m_overflow,  0);
    endtask

    // Called at a negedge with s_ready expected high. bub_pct < 0 selects the
    // fixed pattern of two bubbles after the first sample.
    task automatic run_edge(input int bub_pct, input int stall, input bit hold_sv);
        int          sent;
        int          cyc;
        int          gap;
        bit          xfer;
        bit          bub;
        logic [14:0] cur;
        sent = 0;
        cyc  = 0;
        gap  = 0;
        model();
        m_ready = (stall == 0);
        while (sent < q_code.size() && cyc < 4000) begin
            if (bub_pct < 0) bub = (sent == 1 && gap < 2);
            else             bub = ($urandom_range(99) < bub_pct);
            if (bub) begin
                if (sent == 1) gap++;
                s_valid = 1'b0;
                s_code  = 15'($urandom);
                s_last  = 1'($urandom);
            end else begin
                s_valid = 1'b1;
                s_code  = q_code[sent];
                s_last  = (sent == q_code.size() - 1);
            end
            xfer = s_valid && s_ready;
            cur  = s_code;
            @(negedge clk);
            cyc++;
            if (xfer) begin
                sent++;
                check("chk_valid_on", chk_valid, 1);
                check("chk_code", chk_code, cur);
            end else begin
                check("chk_valid_off", chk_valid, 0);
            end
        end
        if (cyc >= 4000) check("send_timeout", 0, 1);

        s_valid = hold_sv;
        s_code  = 15'($urandom) & 15'h3FFF;
        s_last  = 1'b0;
        check("lat_early_m_valid", m_valid, 0);
        check("lat_early_s_ready", s_ready, 0);
        @(negedge clk);
        check("m_valid", m_valid, 1);
        check("m_blocked", m_blocked, e_blocked);
        check("m_first_idx", m_first_idx, e_first);
        check("m_hits", m_hits, e_hits);
        check("m_overflow", m_overflow, e_ovf);
        check("hold_s_ready", s_ready, 0);
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            check("bp_m_valid", m_valid, 1);
            check("bp_s_ready", s_ready, 0);
            check("bp_m_blocked", m_blocked, e_blocked);
            check("bp_m_first", m_first_idx, e_first);
            check("bp_m_hits", m_hits, e_hits);
            check("bp_m_ovf", m_overflow, e_ovf);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("post_m_valid", m_valid, 0);
        check("post_s_ready", s_ready, 1);
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_code  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check("rst_release_s_ready", s_ready, 0);
        @(negedge clk);
        check("ready_after_rst", s_ready, 1);

        // free edge
        make_edge(5, 0);
        run_edge(0, 0, 1'b0);

        // blocked edge: hits at 3 and 6
        make_edge(8, 0);
        q_code[3][14] = 1'b1;
        q_code[6][14] = 1'b1;
        run_edge(0, 0, 1'b0);

        // backpressure with s_valid held high
        make_edge(4, 50);
        run_edge(0, 10, 1'b1);

        // bubbles: 1,0,0,1(last), hit on second sample
        make_edge(2, 0);
        q_code[1][14] = 1'b1;
        run_edge(-1, 0, 1'b0);

        // single colliding sample
        make_edge(1, 0);
        q_code[0][14] = 1'b1;
        run_edge(0, 0, 1'b0);

        // overflow: the only hit lands beyond the saturated index
        make_edge(66, 0);
        q_code[65][14] = 1'b1;
        run_edge(0, 0, 1'b0);

        // exactly MAX_SAMPLES, no overflow
        make_edge(64, 0);
        q_code[63][14] = 1'b1;
        run_edge(20, 0, 1'b0);

        // asynchronous reset after 3 colliding samples
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_code  = 15'h4000 | 15'(i);
            s_last  = 1'b0;
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        check("async_rst_no_result", m_valid, 0);
        rst = 1'b0;
        #1;
        check("async_release_s_ready", s_ready, 0);
        @(negedge clk);
        check("async_ready_after", s_ready, 1);
        make_edge(2, 0);
        q_code[1][14] = 1'b1;
        run_edge(0, 0, 1'b0);

        // randomized edges
        repeat (20) begin
            make_edge($urandom_range(1, 70), $urandom_range(0, 40));
            run_edge($urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
